mem_sram_responder: RTL

- Data-memory responder for the 5-stage pipeline's MEM stage.
- Accepts 32-bit word read/write requests and serves each one as two 16-bit accesses to an external asynchronous SRAM.
- Holds `ready` low while busy, so the pipeline freezes IF through MEM until the access completes.
- Sits between the MEM stage and the board SRAM pins.

---
 rtl/mem_sram_responder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_sram_responder.sv
// MEM-stage data responder: each 32-bit word access becomes two 16-bit
// asynchronous SRAM accesses (LO then HI). Optional range check: MEM_BOUNDS_CHECK_EN.
module mem_sram_responder #(
    parameter int unsigned ADDR_BASE   = 1024,
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
`ifdef MEM_BOUNDS_CHECK_EN
    ,
    output logic               err
`endif
);

    localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [CW-1:0]          cnt_reg;
    logic                   is_write_reg;
    logic [SRAM_AW-2:0]     word_reg;
    logic [31:0]            wdata_reg;

    logic                   req;
    logic                   accept;
    logic                   phase_last;
    logic [31:0]            offset;
    logic                   unused_offset_bits;

    assign req        = mem_r_en | mem_w_en;
    assign accept     = (state_reg == IDLE) && req;
    assign phase_last = (cnt_reg == CNT_LAST);

    // Word index is offset>>2; bits above the SRAM size are dropped so the map wraps.
    assign offset             = addr - 32'(ADDR_BASE);
    assign unused_offset_bits = ^{offset[1:0], offset[31:SRAM_AW+1]};

`ifdef MEM_BOUNDS_CHECK_EN
    logic out_of_range;
    assign out_of_range = (addr < 32'(ADDR_BASE)) || (|offset[31:SRAM_AW+1]);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
`ifdef MEM_BOUNDS_CHECK_EN
                    state_next = out_of_range ? DONE : LO;
`else
                    state_next = LO;
`endif
                end
            end
            LO:      if (phase_last) state_next = HI;
            HI:      if (phase_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic; the SRAM pins are driven from the request captured at accept
    // so a master dropping its enables mid-access cannot corrupt the strobe.
    always_comb begin
        ready       = ((state_reg == IDLE) && !req) || (state_reg == DONE);
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state_reg)
            LO: begin
                sram_addr = {word_reg, 1'b0};
                if (is_write_reg) begin
                    sram_dq_out = wdata_reg[15:0];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
            end
            HI: begin
                sram_addr = {word_reg, 1'b1};
                if (is_write_reg) begin
                    sram_dq_out = wdata_reg[31:16];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // Phase counter: restarts at zero for each half-access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (((state_reg == LO) || (state_reg == HI)) && !phase_last) begin
            cnt_reg <= cnt_reg + 1'b1;
        end else begin
            cnt_reg <= '0;
        end
    end

    // Request capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            is_write_reg <= 1'b0;
            word_reg     <= '0;
            wdata_reg    <= '0;
        end else if (accept) begin
            is_write_reg <= mem_w_en;
            word_reg     <= offset[SRAM_AW:2];
            wdata_reg    <= wr_data;
        end
    end

    // Read data: each half is sampled on the last cycle of its phase.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
        end else begin
`ifdef MEM_BOUNDS_CHECK_EN
            if (accept && out_of_range) begin
                rd_data <= '0;
            end
`endif
            if ((state_reg == LO) && phase_last && !is_write_reg) begin
                rd_data[15:0] <= sram_dq_in;
            end
            if ((state_reg == HI) && phase_last && !is_write_reg) begin
                rd_data[31:16] <= sram_dq_in;
            end
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (accept && out_of_range) begin
            err <= 1'b1;
        end
    end
`endif

endmodule
